// File: rtl/canvas_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | canvas_ctrl: 1-bit drawing canvas with auto-repeat cursor keys, pen, clear |
// |              sweep, synchronous read port and continuous VGA rasteriser.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module canvas_ctrl #(
    parameter int GRID_W       = 28,
    parameter int GRID_H       = 28,
    parameter int PIXEL_SIZE   = 4,
    parameter int REPEAT_DELAY = 2000000
) (
    input  logic                                CLOCK_50,
    input  logic                                resetn,
    input  logic [3:0]                          key_n,
    input  logic                                pen_en,
    input  logic                                erase,
    input  logic                                clear,
    input  logic [$clog2(GRID_W*GRID_H)-1:0]    rd_addr,
    output logic                                rd_data,
    output logic [$clog2(GRID_W)-1:0]           cursor_x,
    output logic [$clog2(GRID_H)-1:0]           cursor_y,
    output logic                                clear_busy,
    output logic [7:0]                          vga_x,
    output logic [6:0]                          vga_y,
    output logic [2:0]                          vga_colour,
    output logic                                vga_plot,
    output logic                                frame_done
);

    localparam int CELLS  = GRID_W * GRID_H;
    localparam int AW     = $clog2(CELLS);
    localparam int XW     = $clog2(GRID_W);
    localparam int YW     = $clog2(GRID_H);
    localparam int CW     = $clog2(REPEAT_DELAY);
    localparam int SH     = $clog2(PIXEL_SIZE);
    localparam int PX_MAX = GRID_W * PIXEL_SIZE - 1;
    localparam int PY_MAX = GRID_H * PIXEL_SIZE - 1;

    localparam logic [CW-1:0] RELOAD    = CW'(REPEAT_DELAY - 1);
    localparam logic [XW-1:0] X_MAX     = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX     = YW'(GRID_H - 1);
    localparam logic [XW-1:0] X_RST     = XW'(GRID_W / 2);
    localparam logic [YW-1:0] Y_RST     = YW'(GRID_H / 2);
    localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
    localparam logic [AW:0]   CELLS_W   = (AW+1)'(CELLS);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      clr_cnt_q, clr_cnt_d;
    logic [3:0]         key_s1_q, key_s2_q;
    logic [3:0]         key_prev_q, key_prev_d;
    logic [3:0][CW-1:0] cnt_q, cnt_d;
    logic [XW-1:0]      cursor_x_q, cursor_x_d;
    logic [YW-1:0]      cursor_y_q, cursor_y_d;
    logic               rd_data_q, rd_data_d;
    logic [7:0]         px_q, px_d;
    logic [6:0]         py_q, py_d;
    logic               s1_valid_q, s1_valid_d;
    logic [7:0]         s1_x_q, s1_x_d;
    logic [6:0]         s1_y_q, s1_y_d;
    logic               s1_last_q, s1_last_d;
    logic               s1_set_q, s1_set_d;
    logic               s1_cur_q, s1_cur_d;
    logic [7:0]         vga_x_q, vga_x_d;
    logic [6:0]         vga_y_q, vga_y_d;
    logic [2:0]         vga_colour_q, vga_colour_d;
    logic               vga_plot_q, vga_plot_d;
    logic               frame_done_q, frame_done_d;

    logic               mem [0:CELLS-1];

    logic [3:0]         w_key_act;
    logic [3:0]         w_step;
    logic               w_wr_en;
    logic [AW-1:0]      w_wr_addr;
    logic               w_wr_data;
    logic [AW-1:0]      w_paint_addr;
    logic [XW-1:0]      w_scan_cx;
    logic [YW-1:0]      w_scan_cy;
    logic [AW-1:0]      w_scan_addr;

    assign w_key_act    = ~key_s2_q;
    assign w_paint_addr = AW'(32'(cursor_y_q) * GRID_W + 32'(cursor_x_q));
    assign w_scan_cx    = XW'(px_q >> SH);
    assign w_scan_cy    = YW'(py_q >> SH);
    assign w_scan_addr  = AW'(32'(w_scan_cy) * GRID_W + 32'(w_scan_cx));

    // Control FSM and the single RAM write port (clear sweep or pen).
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        w_wr_en   = 1'b0;
        w_wr_addr = w_paint_addr;
        w_wr_data = ~erase;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (pen_en) begin
                    w_wr_en = 1'b1;
                end
            end
            ST_CLEAR: begin
                w_wr_en   = 1'b1;
                w_wr_addr = clr_cnt_q;
                w_wr_data = 1'b0;
                if (clr_cnt_q == LAST_CELL) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // During a sweep held keys keep their counter preloaded, so the repeat
    // period restarts on exit instead of producing a step.
    always_comb begin
        key_prev_d = w_key_act;
        w_step     = '0;
        cnt_d      = '0;
        for (int i = 0; i < 4; i++) begin
            if (state_q == ST_CLEAR) begin
                if (w_key_act[i]) cnt_d[i] = RELOAD;
            end else if (w_key_act[i]) begin
                if (!key_prev_q[i] || cnt_q[i] == '0) begin
                    w_step[i] = 1'b1;
                    cnt_d[i]  = RELOAD;
                end else begin
                    cnt_d[i] = cnt_q[i] - CW'(1);
                end
            end
        end
    end

    always_comb begin
        cursor_x_d = cursor_x_q;
        cursor_y_d = cursor_y_q;
        if (w_step[3] && !w_key_act[2] && cursor_x_q != X_MAX) cursor_x_d = cursor_x_q + XW'(1);
        if (w_step[2] && !w_key_act[3] && cursor_x_q != '0)    cursor_x_d = cursor_x_q - XW'(1);
        if (w_step[0] && !w_key_act[1] && cursor_y_q != Y_MAX) cursor_y_d = cursor_y_q + YW'(1);
        if (w_step[1] && !w_key_act[0] && cursor_y_q != '0)    cursor_y_d = cursor_y_q - YW'(1);
    end

    always_comb begin
        rd_data_d = 1'b0;
        if ({1'b0, rd_addr} < CELLS_W) rd_data_d = mem[rd_addr];
    end

    // Raster counter, then cell lookup, then registered adapter outputs.
    always_comb begin
        px_d = px_q + 8'd1;
        py_d = py_q;
        if (px_q == 8'(PX_MAX)) begin
            px_d = '0;
            py_d = (py_q == 7'(PY_MAX)) ? 7'd0 : py_q + 7'd1;
        end
        s1_valid_d = 1'b1;
        s1_x_d     = px_q;
        s1_y_d     = py_q;
        s1_last_d  = (px_q == 8'(PX_MAX)) && (py_q == 7'(PY_MAX));
        // The RAM holds garbage until the sweep completes, so show it as blank.
        s1_set_d   = (state_q == ST_IDLE) ? mem[w_scan_addr] : 1'b0;
        s1_cur_d   = (w_scan_cx == cursor_x_q) && (w_scan_cy == cursor_y_q);

        vga_x_d      = s1_x_q;
        vga_y_d      = s1_y_q;
        vga_plot_d   = s1_valid_q;
        frame_done_d = s1_last_q;
        vga_colour_d = s1_cur_q ? 3'b100 : (s1_set_q ? 3'b111 : 3'b001);
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_wr_en) mem[w_wr_addr] <= w_wr_data;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            key_s1_q     <= '1;
            key_s2_q     <= '1;
            key_prev_q   <= '0;
            cnt_q        <= '0;
            cursor_x_q   <= X_RST;
            cursor_y_q   <= Y_RST;
            rd_data_q    <= 1'b0;
            px_q         <= '0;
            py_q         <= '0;
            s1_valid_q   <= 1'b0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            s1_last_q    <= 1'b0;
            s1_set_q     <= 1'b0;
            s1_cur_q     <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            key_s1_q     <= key_n;
            key_s2_q     <= key_s1_q;
            key_prev_q   <= key_prev_d;
            cnt_q        <= cnt_d;
            cursor_x_q   <= cursor_x_d;
            cursor_y_q   <= cursor_y_d;
            rd_data_q    <= rd_data_d;
            px_q         <= px_d;
            py_q         <= py_d;
            s1_valid_q   <= s1_valid_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            s1_last_q    <= s1_last_d;
            s1_set_q     <= s1_set_d;
            s1_cur_q     <= s1_cur_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign cursor_x   = cursor_x_q;
    assign cursor_y   = cursor_y_q;
    assign clear_busy = (state_q == ST_CLEAR);
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_canvas_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_canvas_ctrl: directed self-checking bench for canvas_ctrl (28x28, x4).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_canvas_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] key_n;
    logic       pen_en;
    logic       erase;
    logic       clear;
    logic [9:0] rd_addr;
    logic       rd_data;
    logic [4:0] cursor_x;
    logic [4:0] cursor_y;
    logic       clear_busy;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    canvas_ctrl #(
        .GRID_W      (28),
        .GRID_H      (28),
        .PIXEL_SIZE  (4),
        .REPEAT_DELAY(8)
    ) dut (
        .CLOCK_50  (clk),
        .resetn    (resetn),
        .key_n     (key_n),
        .pen_en    (pen_en),
        .erase     (erase),
        .clear     (clear),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .clear_busy(clear_busy),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .vga_plot  (vga_plot),
        .frame_done(frame_done)
    );

    always #10 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_pix(input int x, input int y, output bit found);
        found = 1'b0;
        for (int i = 0; i < 13000 && !found; i++) begin
            tick(1);
            if (vga_plot && vga_x == 8'(x) && vga_y == 7'(y)) found = 1'b1;
        end
    endtask

    // Called right after resetn is released; walks through the boot sweep and first frame.
    task automatic post_reset(input string p);
        int k;
        tick(1);
        chk({p, "_plot_c1"}, vga_plot, 0);
        tick(1);
        chk({p, "_plot_c2"}, vga_plot, 1);
        chk({p, "_vga_x_c2"}, vga_x, 0);
        chk({p, "_vga_y_c2"}, vga_y, 0);
        chk({p, "_colour_c2"}, vga_colour, 3'b001);
        tick(781);
        chk({p, "_busy_783"}, clear_busy, 1);
        tick(1);
        chk({p, "_busy_784"}, clear_busy, 0);
        chk({p, "_cursor_x"}, cursor_x, 14);
        chk({p, "_cursor_y"}, cursor_y, 14);
        k = 784;
        while (!frame_done && k < 14000) begin
            tick(1);
            k++;
        end
        chk({p, "_first_frame_done"}, k, 12545);
    endtask

    initial begin
        bit found;
        int k;
        resetn  = 1'b0;
        key_n   = 4'hF;
        pen_en  = 1'b0;
        erase   = 1'b0;
        clear   = 1'b0;
        rd_addr = '0;
        tick(3);
        chk("rst_cursor_x", cursor_x, 14);
        chk("rst_cursor_y", cursor_y, 14);
        chk("rst_vga_x", vga_x, 0);
        chk("rst_vga_y", vga_y, 0);
        chk("rst_plot", vga_plot, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", clear_busy, 1);
        resetn = 1'b1;
        post_reset("boot");

        // Paint, erase and repaint cell (14,14) = address 406.
        rd_addr = 10'd406;
        pen_en  = 1'b1;
        tick(1);
        chk("paint_old_value", rd_data, 0);
        pen_en = 1'b0;
        tick(1);
        chk("paint_set", rd_data, 1);
        pen_en = 1'b1;
        erase  = 1'b1;
        tick(1);
        chk("erase_old_value", rd_data, 1);
        pen_en = 1'b0;
        erase  = 1'b0;
        tick(1);
        chk("erase_clr", rd_data, 0);
        pen_en = 1'b1;
        tick(1);
        pen_en = 1'b0;
        tick(1);
        chk("repaint", rd_data, 1);
        rd_addr = 10'd405;
        tick(1);
        chk("neighbour_clear", rd_data, 0);
        rd_addr = 10'd784;
        tick(1);
        chk("rd_oob_784", rd_data, 0);
        rd_addr = 10'd1023;
        tick(1);
        chk("rd_oob_1023", rd_data, 0);

        // Diagonal: right + down together.
        key_n = 4'b0110;
        tick(2);
        chk("diag_sync_x", cursor_x, 14);
        tick(1);
        chk("diag_x", cursor_x, 15);
        chk("diag_y", cursor_y, 15);
        key_n = 4'hF;
        tick(4);

        // Scanner colours: painted cell, cursor cell, empty cell.
        wait_pix(56, 56, found);
        chk("pix_56_56_found", found, 1);
        chk("pix_painted_colour", vga_colour, 3'b111);
        wait_pix(60, 60, found);
        chk("pix_60_60_found", found, 1);
        chk("pix_cursor_colour", vga_colour, 3'b100);
        wait_pix(0, 0, found);
        chk("pix_0_0_found", found, 1);
        chk("pix_empty_colour", vga_colour, 3'b001);

        // Right tap with auto-repeat at 8-cycle spacing.
        key_n = 4'b0111;
        tick(2);
        chk("tap_sync_x", cursor_x, 15);
        tick(1);
        chk("tap_step1", cursor_x, 16);
        tick(7);
        chk("tap_before_repeat", cursor_x, 16);
        tick(1);
        chk("tap_repeat", cursor_x, 17);
        key_n = 4'hF;
        tick(4);
        chk("tap_released", cursor_x, 17);

        key_n = 4'b0111;
        tick(150);
        chk("hold_saturate_x", cursor_x, 27);
        key_n = 4'hF;
        tick(4);

        key_n = 4'b1011;
        tick(3);
        chk("left_step", cursor_x, 26);
        key_n = 4'hF;
        tick(4);
        key_n = 4'b0011;
        tick(30);
        chk("left_right_x", cursor_x, 26);
        chk("left_right_y", cursor_y, 15);
        key_n = 4'hF;
        tick(4);

        // Clear with pen down at (26,15) = address 446; paint must be dropped.
        rd_addr = 10'd446;
        pen_en  = 1'b1;
        clear   = 1'b1;
        tick(1);
        clear  = 1'b0;
        pen_en = 1'b0;
        chk("clr_busy_start", clear_busy, 1);
        tick(1);
        chk("clr_paint_dropped", rd_data, 0);
        key_n = 4'b0111;
        tick(100);
        key_n = 4'hF;
        tick(10);
        tick(672);
        chk("clr_busy_784", clear_busy, 1);
        chk("clr_keys_ignored", cursor_x, 26);
        tick(1);
        chk("clr_busy_done", clear_busy, 0);
        for (int a = 0; a < 784; a++) begin
            rd_addr = 10'(a);
            tick(1);
            chk("clr_cell_zero", rd_data, 0);
        end

        // Frame period.
        k = 0;
        while (!frame_done && k < 13000) begin
            tick(1);
            k++;
        end
        chk("frame_seen", frame_done, 1);
        chk("frame_last_x", vga_x, 111);
        chk("frame_last_y", vga_y, 111);
        k = 0;
        do begin
            tick(1);
            k++;
        end while (!frame_done && k < 13000);
        chk("frame_period", k, 12544);

        // Reset in the middle of a clear sweep and a frame.
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(100);
        chk("mid_busy", clear_busy, 1);
        resetn = 1'b0;
        #1;
        chk("arst_cursor_x", cursor_x, 14);
        chk("arst_cursor_y", cursor_y, 14);
        chk("arst_plot", vga_plot, 0);
        chk("arst_vga_x", vga_x, 0);
        chk("arst_frame_done", frame_done, 0);
        chk("arst_busy", clear_busy, 1);
        tick(2);
        resetn = 1'b1;
        post_reset("rst2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/canvas_ctrl.md
Name: canvas_ctrl

Overview:
Parametrised drawing-canvas controller for the digit-input front end. It holds a GRID_W x GRID_H 1-bit canvas and moves a cursor with auto-repeating keys. It paints or erases one cell under the cursor and clears the canvas on request. It continuously rasters the scaled canvas into the 160x120 VGA adapter, and exposes a synchronous read port so the NN input stage can fetch cells.

Parameters:
GRID_W, 28, canvas width in cells (2..32)
GRID_H, 28, canvas height in cells (2..32)
PIXEL_SIZE, 4, VGA pixels per cell edge; power of 2 (1,2,4); GRID_W*PIXEL_SIZE<=160, GRID_H*PIXEL_SIZE<=120
REPEAT_DELAY, 2000000, cycles between auto-repeat steps of a held key (>=2)

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  asynchronous active-low reset
key_n  in  4  raw active-low buttons: [3] right, [2] left, [1] up, [0] down
pen_en  in  1  level; paint/erase cell under cursor every idle cycle
erase  in  1  level; with pen_en writes 0 instead of 1
clear  in  1  single-cycle request to zero the whole canvas
rd_addr  in  AW  cell address y*GRID_W+x, AW=clog2(GRID_W*GRID_H)
rd_data  out  1  cell value, 1-cycle latency
cursor_x  out  XW  cursor column, XW=clog2(GRID_W)
cursor_y  out  YW  cursor row, YW=clog2(GRID_H)
clear_busy  out  1  high while clear sweep runs
vga_x  out  8  adapter x
vga_y  out  7  adapter y
vga_colour  out  3  adapter colour (RGB 1 bit each)
vga_plot  out  1  adapter plot strobe
frame_done  out  1  one-cycle pulse after last pixel of each frame

Behaviour:
- Reset (async assert, sync release) sets the following values:
  - cursor=(GRID_W/2, GRID_H/2); vga_x=0, vga_y=0, vga_plot=0, frame_done=0, rd_data=0.
  - Repeat counters are zeroed.
  - State is CLEAR with clear_busy=1.
- Canvas RAM has no reset. Every reset is followed by a full clear sweep.
- Control FSM, IDLE state:
  - Movement and paint are both enabled.
  - A clear pulse moves the FSM to CLEAR on the next edge. Any paint in that cycle is discarded.
- Control FSM, CLEAR state:
  - Writes 0 to address 0..GRID_W*GRID_H-1, one per cycle.
  - Lasts exactly GRID_W*GRID_H cycles, then returns to IDLE and drops clear_busy.
  - Keys, pen_en and clear are ignored during CLEAR. A held key's repeat counter restarts on exit.
- Keys:
  - Each key_n bit passes a 2-flop synchroniser and is inverted to active-high.
  - On a press edge the cursor steps by 1 on the next cycle and the key's counter loads REPEAT_DELAY-1.
  - While the key is held, the counter decrements; at 0 the cursor steps again and the counter reloads.
  - On release the counter is cleared.
- Axes are independent:
  - If right and left are both held, x does not move; likewise up and down for y.
  - Diagonal moves are allowed.
- Bounds saturate at 0 and at GRID_W-1 / GRID_H-1. There is no wrap.
- Paint:
  - In IDLE with pen_en=1, cell (cursor_y*GRID_W+cursor_x) is written with ~erase each cycle.
  - The write uses the cursor value before any same-cycle move.
- Read port: rd_data is the registered RAM read of rd_addr.
  - Same-cycle write to the same address returns the old value.
  - rd_addr >= GRID_W*GRID_H returns 0.
- Scanner: a free-running raster over px=0..GRID_W*PIXEL_SIZE-1, py=0..GRID_H*PIXEL_SIZE-1, one pixel per cycle, row-major. It runs during CLEAR too.
- Scanner pipeline:
  - Stage 1 computes the cell (px/PIXEL_SIZE, py/PIXEL_SIZE) and reads the RAM.
  - Stage 2 registers vga_x=px, vga_y=py, vga_plot=1, and vga_colour: 100 if cell==cursor, else 111 if set, else 001.
  - Total latency from counter to outputs is 2 cycles. vga_plot is 0 only for the first 2 cycles after reset.
- frame_done pulses with the vga outputs of the final pixel (last column, last row). The raster then wraps to (0,0).

Test Plan:
- Release reset, hold keys idle -> clear_busy high exactly 784 cycles. Cursor (14,14); first vga_plot at cycle 2 with vga_x=0, vga_y=0, colour 001.
- Tap key_n[3] once (REPEAT_DELAY=8 in bench) -> cursor_x=15 after synchroniser+1 cycle. Hold 20 cycles -> x steps at 8-cycle intervals. Hold at x=27 -> stays 27.
- Hold key_n[3] and key_n[2] together -> cursor_x unchanged. Hold key_n[0]+key_n[3] -> diagonal steps to (15,15).
- pen_en=1 at (14,14), then rd_addr=406 -> rd_data=1 next cycle. erase=1 -> rd_data=0. Scanner colour for that cell is 111 once the cursor moves away.
- clear pulse while pen_en=1 -> no paint that cycle; 784-cycle sweep; all rd_addr 0..783 read 0. Keys during the sweep do not move the cursor.
- Assert resetn low mid-clear and mid-frame -> outputs return immediately to reset values. A fresh full clear follows, and frame_done period equals 112*112 cycles.
